// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b computed LSB-first through one
// full-subtractor cell. The borrow is kept in a register between bit steps.
// One operation takes WIDTH cycles in RUN. The result is then held in DONE
// until the consumer takes it.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid and ready are both high. in_ready and out_valid depend on the
// FSM state only, so neither has a combinational path from in_valid or
// out_ready. The producer may raise in_valid at any time; it is only looked at
// in IDLE. The consumer may raise out_ready at any time; it is only looked at
// in DONE. While out_valid is high, diff/bout/out_valid stay stable until the
// transfer.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             busy
);

   // One extra counter bit keeps WIDTH=1 legal: cnt is then 1 bit wide and
   // LAST is 0, so RUN lasts exactly one cycle.
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] diff_sh;
   logic [WIDTH-1:0] d_msb;
   logic             br;
   logic [CW-1:0]    cnt;

   logic x;
   logic y;
   logic d;
   logic br_next;

   // Full-subtractor cell on the current LSBs, plus the new result bit placed
   // at the MSB so it can be OR-ed into the right-shifted accumulator.
   always_comb begin
      x       = a_sh[0];
      y       = b_sh[0];
      d       = x ^ y ^ br;
      br_next = (~x & y) | (~(x ^ y) & br);
      d_msb   = '0;
      d_msb[WIDTH-1] = d;
   end

   // State register; reset aborts any operation in progress immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs, decoded from state alone.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: load operands on accept, then shift one bit per RUN cycle.
   // diff_sh is not cleared on accept because WIDTH shifts overwrite it fully.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh    <= '0;
         b_sh    <= '0;
         diff_sh <= '0;
         br      <= 1'b0;
         cnt     <= '0;
      end else if (state == IDLE && in_valid) begin
         a_sh <= a;
         b_sh <= b;
         br   <= 1'b0;
         cnt  <= '0;
      end else if (state == RUN) begin
         a_sh    <= a_sh >> 1;
         b_sh    <= b_sh >> 1;
         diff_sh <= (diff_sh >> 1) | d_msb;
         br      <= br_next;
         cnt     <= cnt + CW'(1);
      end
   end

   // The result registers drive the outputs directly; they are only meaningful
   // while out_valid is high.
   always_comb begin
      diff = diff_sh;
      bout = br;
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: WIDTH=8, WIDTH=1 and WIDTH=32 instances.
// Directed vectors use hand-computed results. A random regression checks each
// result against a queue of expected {bout, diff} values.
module tb_serial_subtractor;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [32:0] exp_q[$];

   // ---------------- WIDTH=8 instance ----------------
   logic       in_valid8 = 0, out_ready8 = 0;
   logic       in_ready8, out_valid8, bout8, busy8;
   logic [7:0] a8 = 0, b8 = 0, diff8;

   serial_subtractor #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
      .diff(diff8), .bout(bout8), .busy(busy8));

   // ---------------- WIDTH=1 instance ----------------
   logic       in_valid1 = 0, out_ready1 = 0;
   logic       in_ready1, out_valid1, bout1, busy1;
   logic [0:0] a1 = 0, b1 = 0, diff1;

   serial_subtractor #(.WIDTH(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
      .diff(diff1), .bout(bout1), .busy(busy1));

   // ---------------- WIDTH=32 instance ----------------
   logic        in_valid32 = 0, out_ready32 = 0;
   logic        in_ready32, out_valid32, bout32, busy32;
   logic [31:0] a32 = 0, b32 = 0, diff32;

   serial_subtractor #(.WIDTH(32)) u32 (
      .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
      .a(a32), .b(b32), .out_valid(out_valid32), .out_ready(out_ready32),
      .diff(diff32), .bout(bout32), .busy(busy32));

   // ---------------- driver tasks ----------------
   // One WIDTH=8 operation.
   // lat  : posedges from the accept edge until out_valid is seen.
   // held : outputs stayed stable while stalled.
   // ign  : in_ready=0 and busy=1 throughout RUN.
   // rdy  : in_ready high and out_valid low after the handshake.
   // pulse: drive stray in_valid pulses with junk operands during RUN/DONE.
   task automatic op8(input logic [7:0] a, input logic [7:0] b,
                      input int stall, input bit pulse,
                      output logic [7:0] gd, output logic gb, output int lat,
                      output bit held, output bit ign, output bit rdy);
      @(negedge clk);
      in_valid8  = 1'b1;
      a8         = a;
      b8         = b;
      out_ready8 = (stall == 0);
      @(posedge clk);
      @(negedge clk);
      in_valid8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      lat = 0;
      ign = 1'b1;
      while (!out_valid8 && lat < 100) begin
         if (in_ready8 !== 1'b0 || busy8 !== 1'b1) ign = 1'b0;
         if (pulse) begin
            in_valid8 = 1'b1;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
         in_valid8 = 1'b0;
      end
      gd   = diff8;
      gb   = bout8;
      held = 1'b1;
      for (int s = 0; s < stall; s++) begin
         if (out_valid8 !== 1'b1 || diff8 !== gd || bout8 !== gb || in_ready8 !== 1'b0)
            held = 1'b0;
         if (pulse) begin
            in_valid8 = 1'b1;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
         end
         @(posedge clk);
         @(negedge clk);
         in_valid8 = 1'b0;
      end
      if (out_valid8 !== 1'b1 || diff8 !== gd || bout8 !== gb) held = 1'b0;
      out_ready8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready8 = 1'b0;
      rdy = (in_ready8 === 1'b1) && (out_valid8 === 1'b0);
   endtask

   // One WIDTH=32 operation with an optional out_ready stall.
   task automatic op32(input logic [31:0] a, input logic [31:0] b, input int stall,
                       output logic [31:0] gd, output logic gb, output int lat);
      @(negedge clk);
      in_valid32  = 1'b1;
      a32         = a;
      b32         = b;
      out_ready32 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid32 = 1'b0;
      a32 = $urandom;
      b32 = $urandom;
      lat = 0;
      while (!out_valid32 && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      repeat (stall) @(negedge clk);
      gd = diff32;
      gb = bout32;
      out_ready32 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready32 = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      #12;
      n_checks++;
      if (in_ready8 !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready8);
      end
      n_checks++;
      if (out_valid8 !== 1'b0 || busy8 !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid_busy: got %b/%b expected 0/0", out_valid8, busy8);
      end
      n_checks++;
      if (diff8 !== 8'h00 || bout8 !== 1'b0) begin
         n_fail++; $display("FAIL reset_result: got %h/%b expected 00/0", diff8, bout8);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [7:0] d; logic bo; int lat; bit held, ign, rdy;
      op8(8'h05, 8'h03, 0, 1'b0, d, bo, lat, held, ign, rdy);
      n_checks++;
      if (lat != 8) begin
         n_fail++; $display("FAIL basic_latency: got %0d expected 8", lat);
      end
      n_checks++;
      if (d !== 8'h02 || bo !== 1'b0) begin
         n_fail++; $display("FAIL basic_result: got %h/%b expected 02/0", d, bo);
      end
      n_checks++;
      if (!ign) begin
         n_fail++; $display("FAIL basic_run_flags: got 0 expected 1 (in_ready=0, busy=1 in RUN)");
      end
      n_checks++;
      if (!rdy) begin
         n_fail++; $display("FAIL basic_ready_after: got 0 expected 1");
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] va[3] = '{8'h03, 8'h00, 8'hFF};
      logic [7:0] vb[3] = '{8'h05, 8'h01, 8'hFF};
      logic [7:0] ed[3] = '{8'hFE, 8'hFF, 8'h00};
      logic       eb[3] = '{1'b1, 1'b1, 1'b0};
      logic [7:0] d; logic bo; int lat; bit held, ign, rdy;
      for (int i = 0; i < 3; i++) begin
         op8(va[i], vb[i], 0, 1'b0, d, bo, lat, held, ign, rdy);
         n_checks++;
         if (d !== ed[i] || bo !== eb[i]) begin
            n_fail++;
            $display("FAIL b2b_result[%0d]: got %h/%b expected %h/%b", i, d, bo, ed[i], eb[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] d; logic bo; int lat; bit held, ign, rdy;
      op8(8'h80, 8'h01, 5, 1'b1, d, bo, lat, held, ign, rdy);
      n_checks++;
      if (d !== 8'h7F || bo !== 1'b0) begin
         n_fail++; $display("FAIL bp_result: got %h/%b expected 7f/0", d, bo);
      end
      n_checks++;
      if (!held) begin
         n_fail++; $display("FAIL bp_held: got 0 expected 1 (outputs stable while stalled)");
      end
      n_checks++;
      if (!ign || lat != 8) begin
         n_fail++; $display("FAIL bp_ignore_in_valid: got ign=%0d lat=%0d expected 1/8", ign, lat);
      end
      n_checks++;
      if (!rdy) begin
         n_fail++; $display("FAIL bp_ready_after: got 0 expected 1");
      end
   endtask

   task automatic test_reset_mid_run();
      logic [7:0] d; logic bo; int lat; bit held, ign, rdy;
      @(negedge clk);
      in_valid8 = 1'b1;
      a8 = 8'hFF;
      b8 = 8'h00;
      @(posedge clk);
      @(negedge clk);
      in_valid8 = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (busy8 !== 1'b1) begin
         n_fail++; $display("FAIL midrun_busy: got %b expected 1", busy8);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (busy8 !== 1'b0 || in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun_async_flags: got busy=%b in_ready=%b out_valid=%b expected 0/1/0",
                  busy8, in_ready8, out_valid8);
      end
      n_checks++;
      if (diff8 !== 8'h00 || bout8 !== 1'b0) begin
         n_fail++; $display("FAIL midrun_async_result: got %h/%b expected 00/0", diff8, bout8);
      end
      @(negedge clk);
      rst = 1'b0;
      op8(8'h10, 8'h10, 0, 1'b0, d, bo, lat, held, ign, rdy);
      n_checks++;
      if (d !== 8'h00 || bo !== 1'b0 || lat != 8) begin
         n_fail++; $display("FAIL midrun_next_op: got %h/%b lat=%0d expected 00/0 lat=8", d, bo, lat);
      end
   endtask

   task automatic test_width1();
      // Index i = {a,b}: 00 -> 0/0, 01 -> 1/1, 10 -> 1/0, 11 -> 0/0
      logic [3:0] ed = 4'b0110;
      logic [3:0] eb = 4'b0010;
      logic [1:0] ab;
      int lat;
      for (int i = 0; i < 4; i++) begin
         ab = 2'(i);
         @(negedge clk);
         in_valid1  = 1'b1;
         a1         = ab[1];
         b1         = ab[0];
         out_ready1 = 1'b0;
         @(posedge clk);
         @(negedge clk);
         in_valid1 = 1'b0;
         lat = 0;
         while (!out_valid1 && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
         end
         n_checks++;
         if (lat != 1 || diff1 !== ed[i] || bout1 !== eb[i]) begin
            n_fail++;
            $display("FAIL w1_op[%0d]: got %b/%b lat=%0d expected %b/%b lat=1",
                     i, diff1, bout1, lat, ed[i], eb[i]);
         end
         out_ready1 = 1'b1;
         @(posedge clk);
         @(negedge clk);
         out_ready1 = 1'b0;
      end
   endtask

   task automatic test_random();
      logic [7:0]  ra8, rb8, d8;
      logic [31:0] ra, rb, d32;
      logic        bo;
      logic [32:0] e;
      int lat, st;
      bit held, ign, rdy;
      for (int i = 0; i < 1000; i++) begin
         ra8 = 8'($urandom);
         rb8 = 8'($urandom);
         if (i == 0) begin ra8 = 8'h00; rb8 = 8'hFF; end
         st = $urandom_range(0, 3);
         exp_q.push_back({24'b0, (ra8 < rb8), 8'(ra8 - rb8)});
         op8(ra8, rb8, st, 1'($urandom_range(0, 1)), d8, bo, lat, held, ign, rdy);
         e = exp_q.pop_front();
         n_checks++;
         if ({bo, d8} !== e[8:0] || lat != 8) begin
            n_fail++;
            $display("FAIL rand8[%0d]: a=%h b=%h got %b/%h lat=%0d expected %b/%h lat=8",
                     i, ra8, rb8, bo, d8, lat, e[8], e[7:0]);
         end
      end
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i == 0) begin ra = 32'h0; rb = 32'hFFFF_FFFF; end
         if (i == 1) begin ra = 32'hFFFF_FFFF; rb = 32'h0; end
         st = $urandom_range(0, 3);
         exp_q.push_back({(ra < rb), ra - rb});
         op32(ra, rb, st, d32, bo, lat);
         e = exp_q.pop_front();
         n_checks++;
         if ({bo, d32} !== e || lat != 32) begin
            n_fail++;
            $display("FAIL rand32[%0d]: a=%h b=%h got %b/%h lat=%0d expected %b/%h lat=32",
                     i, ra, rb, bo, d32, lat, e[32], e[31:0]);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_run();
      test_width1();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
               n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
